// File: rtl/bus_responder.sv
// Bus responder: runs one CPU bus command per M-cycle on the byte-wide memory bus (T1..T4 + wait states).
// Latency: 4 clk per M-cycle, plus 1 clk per wait state; m_end, din_valid and bus_err pulse in T4.
// Backpressure: mem_ready low in T3/WAIT stretches the M-cycle (stall=1); WAIT_MAX waits then abort with open-bus data.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   bus_opcode, addr, dout    command, address and write data from the control unit (sampled in T1)
//   next_opcode, din          last byte fetched by IF / read by READ (updated entering T4)
//   din_valid, m_end, bus_err T4 pulses: READ data valid, M-cycle end, timed-out cycle
//   stall                     high while in wait states
//   mem_addr, mem_wdata       external address / write data, held from T2 until the next T2
//   mem_rd, mem_wr            external strobes, T2 through the ready-accept clk
//   mem_rdata, mem_ready      external read data and acknowledge (sampled only in T3/WAIT)

package cpu_pkg;
  typedef enum logic [1:0] {
    BUS_IDLE  = 2'd0,
    BUS_IF    = 2'd1,
    BUS_READ  = 2'd2,
    BUS_WRITE = 2'd3
  } bus_opcode_t;
endpackage

module bus_responder
  import cpu_pkg::*;
#(
  parameter int         T_PER_M  = 4,
  parameter int         WAIT_MAX = 15,
  parameter logic [7:0] OPEN_BUS = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  bus_opcode_t       bus_opcode,
  input  logic [15:0]       addr,
  input  logic [7:0]        dout,
  output logic [7:0]        next_opcode,
  output logic [7:0]        din,
  output logic              din_valid,
  output logic              m_end,
  output logic              stall,
  output logic              bus_err,
  output logic [15:0]       mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready
);

  // The T-state sequence is hard-wired; refuse any other configuration at elaboration.
  if (T_PER_M != 4 || WAIT_MAX < 1 || WAIT_MAX > 255) begin : g_bad_params
    $error("bus_responder: T_PER_M must be 4 and WAIT_MAX must be 1..255");
  end

  typedef enum logic [2:0] {
    S_T1   = 3'd0,
    S_T2   = 3'd1,
    S_T3   = 3'd2,
    S_WAIT = 3'd3,
    S_T4   = 3'd4
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX);

  state_t      state;
  bus_opcode_t cmd_q;
  logic [7:0]  wait_cnt;

  // Completion decision for the T3/WAIT clk: whether this edge leaves for T4,
  // whether it is a timeout, and which byte gets delivered.
  logic       done;
  logic       timeout;
  logic [7:0] cap_dat;

  always_comb begin
    done    = 1'b0;
    timeout = 1'b0;
    cap_dat = mem_rdata;
    case (state)
      S_T3: begin
        // IDLE never waits: the bus is not being used, so ready is irrelevant.
        done = (cmd_q == BUS_IDLE) || mem_ready;
      end
      S_WAIT: begin
        if (mem_ready) begin
          done = 1'b1;
        end else if (wait_cnt == WAIT_LAST) begin
          done    = 1'b1;
          timeout = 1'b1;
          cap_dat = OPEN_BUS;
        end
      end
      default: begin
        done = 1'b0;
      end
    endcase
  end

  // Single registered FSM. All outputs are registers so they change only on
  // clk edges; T4 pulses are set on the edge that enters T4, so din/next_opcode
  // already carry the new byte while din_valid/m_end are high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_T1;
      cmd_q       <= BUS_IDLE;
      wait_cnt    <= 8'd0;
      next_opcode <= 8'h00;
      din         <= 8'h00;
      din_valid   <= 1'b0;
      m_end       <= 1'b0;
      stall       <= 1'b0;
      bus_err     <= 1'b0;
      mem_addr    <= 16'h0000;
      mem_wdata   <= 8'h00;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
    end else begin
      din_valid <= 1'b0;
      m_end     <= 1'b0;
      bus_err   <= 1'b0;

      case (state)
        S_T1: begin
          // Command, address and data are taken here only; later changes on
          // the CPU side cannot disturb a running M-cycle. Loading the bus
          // registers now makes them visible from T2 onwards.
          cmd_q     <= bus_opcode;
          mem_addr  <= addr;
          mem_wdata <= dout;
          mem_rd    <= (bus_opcode == BUS_IF) || (bus_opcode == BUS_READ);
          mem_wr    <= (bus_opcode == BUS_WRITE);
          wait_cnt  <= 8'd0;
          state     <= S_T2;
        end

        S_T2: begin
          state <= S_T3;
        end

        S_T3, S_WAIT: begin
          if (done) begin
            state    <= S_T4;
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            stall    <= 1'b0;
            m_end    <= 1'b1;
            bus_err  <= timeout;
            wait_cnt <= 8'd0;
            case (cmd_q)
              BUS_IF:   next_opcode <= cap_dat;
              BUS_READ: begin
                din       <= cap_dat;
                din_valid <= 1'b1;
              end
              default: begin
                // WRITE/IDLE deliver no data; a timed-out WRITE only flags bus_err.
              end
            endcase
          end else if (state == S_T3) begin
            state    <= S_WAIT;
            stall    <= 1'b1;
            wait_cnt <= 8'd1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        S_T4: begin
          state <= S_T1;
        end

        default: begin
          state <= S_T1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_responder.sv
// Bench for bus_responder: directed scenarios followed by randomized M-cycles.
// A transaction-level model predicts M-cycle length, strobe windows and delivered data.
// The memory side is driven per clk from each transaction's ready delay.

module tb_bus_responder;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  bus_opcode_t bus_opcode;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic [7:0]  next_opcode;
  logic [7:0]  din;
  logic        din_valid;
  logic        m_end;
  logic        stall;
  logic        bus_err;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_rdata;
  logic        mem_ready;

  int checks   = 0;
  int failures = 0;

  // Model state: the last byte the CPU should see from IF and READ.
  logic [7:0] m_next_op = 8'h00;
  logic [7:0] m_din     = 8'h00;

  always #5 clk = ~clk;

  bus_responder #(
    .T_PER_M (4),
    .WAIT_MAX(15),
    .OPEN_BUS(8'hFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_opcode (bus_opcode),
    .addr       (addr),
    .dout       (dout),
    .next_opcode(next_opcode),
    .din        (din),
    .din_valid  (din_valid),
    .m_end      (m_end),
    .stall      (stall),
    .bus_err    (bus_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One M-cycle. Entered just after the edge that puts the DUT in T1, returns
  // just after the edge that starts the next T1.
  //   d        : number of clks mem_ready stays low starting at T3 (>=16 -> timeout)
  //   abort_at : clk index (1-based) during which rst is raised, 0 for none
  task automatic run_txn(input bus_opcode_t op, input logic [15:0] a, input logic [7:0] wd,
                         input logic [7:0] rd, input int d, input int abort_at);
    int         w;
    int         len;
    bit         tmo;
    bit         is_rd;
    bit         is_wr;
    logic [7:0] deliv;
    logic [5:0] exp_flags;
    is_rd = (op == BUS_IF) || (op == BUS_READ);
    is_wr = (op == BUS_WRITE);
    w     = (op == BUS_IDLE) ? 0 : ((d > 15) ? 15 : d);
    tmo   = (op != BUS_IDLE) && (d > 15);
    len   = 4 + w;
    deliv = tmo ? 8'hFF : rd;

    for (int c = 1; c <= len; c++) begin
      if (c == 1) begin
        bus_opcode = op;
        addr       = a;
        dout       = wd;
      end else begin
        bus_opcode = bus_opcode_t'($urandom_range(0, 3));
        addr       = 16'($urandom);
        dout       = 8'($urandom);
      end
      if (c >= 3 && c < len) mem_ready = (c >= 3 + d);
      else                   mem_ready = 1'($urandom);
      mem_rdata = mem_ready ? rd : 8'($urandom);
      if (c == abort_at) rst = 1'b1;

      @(negedge clk);
      if (c == len) begin
        if (op == BUS_IF)   m_next_op = deliv;
        if (op == BUS_READ) m_din     = deliv;
      end
      exp_flags = {c == len,
                   c >= 4 && c <= 3 + w,
                   is_rd && c >= 2 && c <= len - 1,
                   is_wr && c >= 2 && c <= len - 1,
                   c == len && op == BUS_READ,
                   c == len && tmo};
      chk($sformatf("flags{m_end,stall,rd,wr,dv,err} op%0d c%0d", op, c),
          32'({m_end, stall, mem_rd, mem_wr, din_valid, bus_err}), 32'(exp_flags));
      chk($sformatf("din op%0d c%0d", op, c), 32'(din), 32'(m_din));
      chk($sformatf("next_opcode op%0d c%0d", op, c), 32'(next_opcode), 32'(m_next_op));
      if (c >= 2) begin
        chk($sformatf("mem_addr op%0d c%0d", op, c), 32'(mem_addr), 32'(a));
        chk($sformatf("mem_wdata op%0d c%0d", op, c), 32'(mem_wdata), 32'(wd));
      end

      @(posedge clk);
      #1;
      if (c == abort_at) begin
        rst       = 1'b0;
        m_next_op = 8'h00;
        m_din     = 8'h00;
        break;
      end
    end
  endtask

  initial begin
    int d;
    int w;
    int ab;
    bus_opcode_t op;

    rst        = 1'b1;
    bus_opcode = BUS_IDLE;
    addr       = 16'h0000;
    dout       = 8'h00;
    mem_rdata  = 8'h00;
    mem_ready  = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset flags", 32'({m_end, stall, mem_rd, mem_wr, din_valid, bus_err}), 32'd0);
    chk("reset next_opcode", 32'(next_opcode), 32'h00);
    chk("reset din", 32'(din), 32'h00);
    chk("reset mem_addr", 32'(mem_addr), 32'h0000);
    chk("reset mem_wdata", 32'(mem_wdata), 32'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed scenarios.
    run_txn(BUS_IF,    16'h0100, 8'h00, 8'h3C, 0,   0);
    run_txn(BUS_READ,  16'hC000, 8'h11, 8'hA5, 3,   0);
    run_txn(BUS_WRITE, 16'hFF80, 8'h5A, 8'h77, 0,   0);
    run_txn(BUS_READ,  16'h1234, 8'h22, 8'h99, 255, 0);
    run_txn(BUS_IDLE,  16'h4321, 8'h33, 8'h44, 255, 0);
    run_txn(BUS_IF,    16'h0200, 8'h00, 8'hC3, 0,   0);
    run_txn(BUS_READ,  16'h0201, 8'h00, 8'h12, 0,   0);
    run_txn(BUS_WRITE, 16'h0202, 8'hE7, 8'h34, 0,   0);
    run_txn(BUS_IDLE,  16'h0203, 8'h00, 8'h56, 0,   0);
    run_txn(BUS_IF,    16'h0300, 8'h00, 8'h8E, 16,  0);
    run_txn(BUS_WRITE, 16'h0301, 8'h6B, 8'h00, 20,  0);
    run_txn(BUS_READ,  16'h0302, 8'h00, 8'h5F, 15,  0);
    run_txn(BUS_READ,  16'hC000, 8'h00, 8'hA5, 255, 8);
    run_txn(BUS_IF,    16'h0000, 8'h00, 8'h00, 1,   0);

    // Randomized M-cycles, occasionally reset inside a wait state.
    for (int n = 0; n < 120; n++) begin
      op = bus_opcode_t'($urandom_range(0, 3));
      d  = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(14, 17));
      w  = (op == BUS_IDLE) ? 0 : ((d > 15) ? 15 : d);
      ab = 0;
      if (w > 0 && $urandom_range(0, 11) == 0) ab = int'($urandom_range(4, 3 + w));
      run_txn(op, 16'($urandom), 8'($urandom), 8'($urandom), d, ab);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
